// File: rtl/vga_pkg.sv
// Shared VGA types and default 640x480@60 timing constants.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {ST_IDLE, ST_RUN} vga_state_t;

  typedef struct packed {
    int unsigned hactive;
    int unsigned hfp;
    int unsigned hsync;
    int unsigned hbp;
    int unsigned vactive;
    int unsigned vfp;
    int unsigned vsync;
    int unsigned vbp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    hactive: 640, hfp: 16, hsync: 96, hbp: 48,
    vactive: 480, vfp: 10, vsync: 2,  vbp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam int unsigned VGA_HACTIVE = VGA_640X480_60.hactive;
  localparam int unsigned VGA_HFP     = VGA_640X480_60.hfp;
  localparam int unsigned VGA_HSYNC   = VGA_640X480_60.hsync;
  localparam int unsigned VGA_HBP     = VGA_640X480_60.hbp;
  localparam int unsigned VGA_VACTIVE = VGA_640X480_60.vactive;
  localparam int unsigned VGA_VFP     = VGA_640X480_60.vfp;
  localparam int unsigned VGA_VSYNC   = VGA_640X480_60.vsync;
  localparam int unsigned VGA_VBP     = VGA_640X480_60.vbp;

  function automatic int unsigned vga_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Reset-to-inactive shift register; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned           WIDTH   = 1,
  parameter int unsigned           DEPTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster generator with pixel-fetch port and latency-matched DAC outputs.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int unsigned HACTIVE  = VGA_HACTIVE,
  parameter int unsigned HFP      = VGA_HFP,
  parameter int unsigned HSYNC    = VGA_HSYNC,
  parameter int unsigned HBP      = VGA_HBP,
  parameter int unsigned VACTIVE  = VGA_VACTIVE,
  parameter int unsigned VFP      = VGA_VFP,
  parameter int unsigned VSYNC    = VGA_VSYNC,
  parameter int unsigned VBP      = VGA_VBP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE_LAT = 2,
  localparam int unsigned HTOTAL  = vga_total(HACTIVE, HFP, HSYNC, HBP),
  localparam int unsigned VTOTAL  = vga_total(VACTIVE, VFP, VSYNC, VBP),
  localparam int unsigned HW      = $clog2(HTOTAL),
  localparam int unsigned VW      = $clog2(VTOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [23:0]   pixel_color,
  output logic          pix_req,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_start,
  output logic          running,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          VGA_SYNC_n
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned D  = PIPE_LAT + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(HACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(HACTIVE + HFP);
  localparam logic [HW-1:0] HS_LAST  = HW'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(VACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(VACTIVE + VFP);
  localparam logic [VW-1:0] VS_LAST  = VW'(VACTIVE + VFP + VSYNC - 1);

  vga_state_t    state;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          pix_ce;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          blank_n_raw;
  logic          clk_raw;
  logic          cap;
  logic [3:0]    pins_d;
  rgb_t          color_q;

  assign pix_ce = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= pix_ce ? '0 : div_cnt + DW'(1);
  end

  // enable is only looked at on the last pix_ce of a frame (or any pix_ce while idle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      h       <= '0;
      v       <= '0;
      running <= 1'b0;
    end else if (pix_ce) begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
              v <= '0;
              if (!enable) begin
                state   <= ST_IDLE;
                running <= 1'b0;
              end
            end else begin
              v <= v + VW'(1);
            end
          end else begin
            h <= h + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign active      = (h < H_ACT) && (v < V_ACT);
  assign pix_req     = running && active && (div_cnt == '0);
  assign line_start  = running && (div_cnt == '0) && (h == '0);
  assign frame_start = line_start && (v == '0);
  assign pix_x       = h;
  assign pix_y       = v;

  assign hs_raw      = (running && (h >= HS_FIRST) && (h <= HS_LAST)) ? HS_POL : ~HS_POL;
  assign vs_raw      = (running && (v >= VS_FIRST) && (v <= VS_LAST)) ? VS_POL : ~VS_POL;
  assign blank_n_raw = running && active;
  assign clk_raw     = (div_cnt >= DIV_HALF);

  vga_delay_line #(
    .WIDTH   (4),
    .DEPTH   (D),
    .RST_VAL ({1'b0, ~HS_POL, ~VS_POL, 1'b0})
  ) u_pin_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({clk_raw, hs_raw, vs_raw, blank_n_raw}),
    .q       (pins_d)
  );

  // Capture strobe trails pix_req by exactly PIPE_LAT cycles, one less than the pin delay.
  vga_delay_line #(
    .WIDTH   (1),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (1'b0)
  ) u_req_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pix_req),
    .q       (cap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  color_q <= '0;
    else if (cap)  color_q <= rgb_t'(pixel_color);
  end

  assign {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n} = pins_d;

  assign VGA_R      = pins_d[0] ? color_q.r : '0;
  assign VGA_G      = pins_d[0] ? color_q.g : '0;
  assign VGA_B      = pins_d[0] ? color_q.b : '0;
  assign VGA_SYNC_n = 1'b0;

endmodule
